// File: rtl/full_adder_if.sv
// rtl/full_adder_if.sv - operand/result bundle for full_adder
// carry_cnt is present only when FULL_ADDER_STATS_EN is defined.
interface full_adder_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c;
  logic             in_valid;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             out_valid;
`ifdef FULL_ADDER_STATS_EN
  logic [CNT_W-1:0] carry_cnt;
`endif

`ifdef FULL_ADDER_STATS_EN
  modport master (
    output a, b, c, in_valid,
    input  sum, carry, sum_q, carry_q, out_valid, carry_cnt
  );
  modport slave (
    input  a, b, c, in_valid,
    output sum, carry, sum_q, carry_q, out_valid, carry_cnt
  );
`else
  modport master (
    output a, b, c, in_valid,
    input  sum, carry, sum_q, carry_q, out_valid
  );
  modport slave (
    input  a, b, c, in_valid,
    output sum, carry, sum_q, carry_q, out_valid
  );
`endif
endinterface

// File: rtl/full_adder.sv
// rtl/full_adder.sv - ripple-carry adder with combinational and registered results
// Optional saturating carry-event counter enabled by FULL_ADDER_STATS_EN.
module full_adder #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input logic        clk,
  input logic        rst,
  full_adder_if.slave bus
);

  logic [WIDTH:0]   cy;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] sum_r;
  logic             carry_r;
  logic             valid_r;

  // Ripple chain of 1-bit cells; in_valid never enters this path.
  assign cy[0] = bus.c;
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign s[i]    = bus.a[i] ^ bus.b[i] ^ cy[i];
    assign cy[i+1] = (bus.a[i] & bus.b[i]) | (bus.a[i] & cy[i]) | (bus.b[i] & cy[i]);
  end

  assign bus.sum   = s;
  assign bus.carry = cy[WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_r   <= '0;
      carry_r <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      valid_r <= bus.in_valid;
      if (bus.in_valid) begin
        sum_r   <= s;
        carry_r <= cy[WIDTH];
      end
    end
  end

  assign bus.sum_q     = sum_r;
  assign bus.carry_q   = carry_r;
  assign bus.out_valid = valid_r;

`ifdef FULL_ADDER_STATS_EN
  logic [CNT_W-1:0] cnt;

  // Saturates at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (bus.in_valid && cy[WIDTH] && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bus.carry_cnt = cnt;
`endif

endmodule

// File: tb/tb_full_adder.sv
// tb/tb_full_adder.sv - directed self-checking bench for full_adder
// Counter checks are compiled only when FULL_ADDER_STATS_EN is defined.
module tb_full_adder;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  full_adder_if #(.WIDTH(1), .CNT_W(8)) if1 ();
  full_adder_if #(.WIDTH(8), .CNT_W(2)) if8 ();

  full_adder #(.WIDTH(1), .CNT_W(8)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
  full_adder #(.WIDTH(8), .CNT_W(2)) u8 (.clk(clk), .rst(rst), .bus(if8.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0] exp_sum1;
  logic [7:0] exp_cy1;
  logic [7:0] exp_cnt [5];

  initial begin
    checks   = 0;
    errors   = 0;
    exp_sum1 = 8'b1001_0110;
    exp_cy1  = 8'b1110_1000;
    exp_cnt  = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd3};

    rst = 1'b1;
    if1.a = '0; if1.b = '0; if1.c = 1'b0; if1.in_valid = 1'b0;
    if8.a = '0; if8.b = '0; if8.c = 1'b0; if8.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_sum_q1",     if1.sum_q,     0);
    check("rst_carry_q1",   if1.carry_q,   0);
    check("rst_out_valid1", if1.out_valid, 0);
    check("rst_sum_q8",     if8.sum_q,     0);
    check("rst_out_valid8", if8.out_valid, 0);
`ifdef FULL_ADDER_STATS_EN
    check("rst_cnt", if8.carry_cnt, 0);
`endif
    rst = 1'b0;

    // Truth table for the 1-bit cell.
    for (int i = 0; i < 8; i++) begin
      {if1.a, if1.b, if1.c} = 3'(i);
      #5;
      check($sformatf("tt_sum_%0d", i),   if1.sum,   exp_sum1[i]);
      check($sformatf("tt_carry_%0d", i), if1.carry, exp_cy1[i]);
    end
    check("tt_no_capture", if1.sum_q, 0);

    // Single capture, then hold.
    @(negedge clk);
    if1.a = 1'b1; if1.b = 1'b1; if1.c = 1'b0; if1.in_valid = 1'b1;
    @(negedge clk);
    check("cap_sum_q",     if1.sum_q,     0);
    check("cap_carry_q",   if1.carry_q,   1);
    check("cap_out_valid", if1.out_valid, 1);
    if1.a = 1'b0; if1.in_valid = 1'b0;
    @(negedge clk);
    check("hold_out_valid", if1.out_valid, 0);
    check("hold_sum_q",     if1.sum_q,     0);
    check("hold_carry_q",   if1.carry_q,   1);
    check("hold_comb_sum",  if1.sum,       1);

    // Unknown in_valid must not disturb the combinational result.
    if1.in_valid = 1'bx;
    if1.a = 1'b1; if1.b = 1'b0; if1.c = 1'b1;
    #1;
    check("x_valid_sum",   if1.sum,   0);
    check("x_valid_carry", if1.carry, 1);
    if1.in_valid = 1'b0;

    // 8-bit combinational vectors.
    if8.a = 8'hFF; if8.b = 8'h01; if8.c = 1'b1; #1;
    check("w8_ff_01_sum",   if8.sum,   8'h01);
    check("w8_ff_01_carry", if8.carry, 1);
    if8.a = 8'hFF; if8.b = 8'hFF; if8.c = 1'b1; #1;
    check("w8_wrap_sum",    if8.sum,   8'hFF);
    check("w8_wrap_carry",  if8.carry, 1);
    if8.a = 8'h5A; if8.b = 8'h35; if8.c = 1'b0; #1;
    check("w8_mid_sum",     if8.sum,   8'h8F);
    check("w8_mid_carry",   if8.carry, 0);
    if8.a = 8'h80; if8.b = 8'h80; if8.c = 1'b0; #1;
    check("w8_msb_sum",     if8.sum,   8'h00);
    check("w8_msb_carry",   if8.carry, 1);

    // Capture, then reset colliding with in_valid.
    @(negedge clk);
    if8.a = 8'h12; if8.b = 8'h34; if8.c = 1'b0; if8.in_valid = 1'b1;
    @(negedge clk);
    check("w8_cap_sum_q",     if8.sum_q,     8'h46);
    check("w8_cap_out_valid", if8.out_valid, 1);
    rst = 1'b1;
    if8.a = 8'hFF; if8.b = 8'hFF; if8.c = 1'b1;
    #1;
    check("rst_comb_sum",   if8.sum,   8'hFF);
    check("rst_comb_carry", if8.carry, 1);
    @(negedge clk);
    check("rstv_sum_q",     if8.sum_q,     0);
    check("rstv_carry_q",   if8.carry_q,   0);
    check("rstv_out_valid", if8.out_valid, 0);
    check("rstv_comb_sum",  if8.sum,       8'hFF);
`ifdef FULL_ADDER_STATS_EN
    check("rstv_cnt", if8.carry_cnt, 0);
`endif
    rst = 1'b0;

    // Five carry-producing captures; the 2-bit counter saturates at 3.
    if8.a = 8'hFF; if8.b = 8'h01; if8.c = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("run_sum_q_%0d", k),   if8.sum_q,     8'h00);
      check($sformatf("run_carry_q_%0d", k), if8.carry_q,   1);
      check($sformatf("run_valid_%0d", k),   if8.out_valid, 1);
`ifdef FULL_ADDER_STATS_EN
      check($sformatf("run_cnt_%0d", k), if8.carry_cnt, exp_cnt[k]);
`endif
    end
    if8.in_valid = 1'b0;
    @(negedge clk);
    check("end_out_valid", if8.out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/full_adder.md
FULL_ADDER -- requirements
Module: full_adder

Interface
REQ-001 Parameter WIDTH, default 1: operand width in bits; legal range 1..64.
REQ-002 Parameter CNT_W, default 8: width of the carry-event counter.
REQ-003 The block SHALL use one clock, and its reset SHALL be synchronous and active-high.
REQ-004 Port clk, input, 1 bit: rising-edge clock for all registers.
REQ-005 Port rst, input, 1 bit: synchronous active-high reset.
REQ-006 Port a, input, WIDTH bits: addend A.
REQ-007 Port b, input, WIDTH bits: addend B.
REQ-008 Port c, input, 1 bit: carry-in.
REQ-009 Port in_valid, input, 1 bit: qualifies a/b/c for capture into the registered stage.
REQ-010 Port sum, output, WIDTH bits: combinational sum.
REQ-011 Port carry, output, 1 bit: combinational carry-out.
REQ-012 Port sum_q, output, WIDTH bits: registered sum.
REQ-013 Port carry_q, output, 1 bit: registered carry-out.
REQ-014 Port out_valid, output, 1 bit: sum_q/carry_q hold a freshly captured result.
REQ-015 Port carry_cnt, output, CNT_W bits: count of captured results with carry=1; the port exists only with FULL_ADDER_STATS_EN.

Function
REQ-016 {carry, sum} SHALL equal a + b + c, computed at WIDTH+1 bits with no truncation.
REQ-017 sum and carry SHALL be purely combinational, independent of clk, rst and in_valid, and settle within the same time step as any input change.
REQ-018 For WIDTH=1: sum = a^b^c; carry = (a&b)|(a&c)|(b&c).
REQ-019 The carry chain SHALL be a ripple of 1-bit full-adder cells; bit i carry-in is bit i-1 carry-out, and bit 0 carry-in is c.
REQ-020 When in_valid=1 at a rising clk edge, sum_q/carry_q SHALL capture sum/carry, so the result is visible 1 cycle after capture.
REQ-021 When in_valid=0 at a rising clk edge, sum_q/carry_q SHALL hold their values.
REQ-022 out_valid SHALL be in_valid delayed by one clock cycle.
REQ-023 An undriven (X/Z) in_valid SHALL NOT affect sum or carry.
REQ-024 Wrap-around: all-ones + all-ones + 1 SHALL give sum = all-ones and carry = 1.

Reset
REQ-025 When rst=1 at a rising clk edge, sum_q, carry_q and out_valid SHALL be 0, and carry_cnt SHALL be 0 when present.
REQ-026 Reset SHALL take priority over a simultaneous in_valid=1; that input is discarded.
REQ-027 Reset SHALL have no effect on the combinational sum and carry outputs.
REQ-028 The first capture after reset SHALL occur at the first edge where rst=0 and in_valid=1.

Configuration
REQ-029 With macro FULL_ADDER_STATS_EN defined, carry_cnt SHALL increment by 1 on each edge where rst=0, in_valid=1 and carry=1.
REQ-030 With FULL_ADDER_STATS_EN defined, carry_cnt SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-031 Without FULL_ADDER_STATS_EN, the carry_cnt port and counter logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-032 WIDTH=1, clk idle, {a,b,c} stepped 000..111 every 5 ns -> sum/carry = 0/0, 1/0, 1/0, 0/1, 1/0, 0/1, 0/1, 1/1.
REQ-033 WIDTH=1, a=1, b=1, c=0, in_valid=1 for one edge -> next cycle sum_q=0, carry_q=1, out_valid=1; following cycle with in_valid=0 -> out_valid=0 and sum_q/carry_q hold.
REQ-034 WIDTH=8, a=8'hFF, b=8'h01, c=1 -> sum=8'h01, carry=1; and a=8'hFF, b=8'hFF, c=1 -> sum=8'hFF, carry=1.
REQ-035 rst=1 asserted together with in_valid=1 mid-stream -> next cycle sum_q=0, carry_q=0, out_valid=0, carry_cnt=0, while combinational outputs still track inputs.
REQ-036 FULL_ADDER_STATS_EN defined, CNT_W=2, five consecutive captures with carry=1 -> carry_cnt reads 1, 2, 3, 3, 3.
